// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count_sched scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  // Counter channel select values driven on CntSlt.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Strobes per channel-1 transaction; must match the counter's prescale.
  localparam int BEATS1_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set Req bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is taken.
// Ports: Req (N request bits), ptr (search start), Valid (any Req set),
//        GrantId (index of winner, 0 when Valid=0).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         Req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 Valid,
  output logic [$clog2(N)-1:0] GrantId
);

  localparam int GW = $clog2(N);

  // Scan offsets from the farthest to the nearest so the nearest set bit
  // (lowest offset from ptr) is the last write and therefore wins.
  always_comb begin
    Valid   = 1'b0;
    GrantId = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (Req[(int'(ptr) + i) % N]) begin
        Valid   = 1'b1;
        GrantId = GW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler serialising N requesters onto one dual-channel counter.
// Latency: Req seen in IDLE cycle t -> first CntEn at t+1; ch0 2 cycles, ch1 1+BEATS1.
// Backpressure: Req/ClrReq are held levels until Ack/ClrAck; only arbitrated in IDLE.
// Ports: Clk, Reset (sync, active-high); Req/Sel per requester; Ack one-hot;
//        ClrReq/ClrAck clear handshake; CntEn/CntSlt/CntRst counter controls;
//        Busy (non-IDLE), GrantId (current grantee, 0 when idle). All outputs registered.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int N      = 4,
  parameter int BEATS1 = BEATS1_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N-1:0]         Req,
  input  logic [N-1:0]         Sel,
  output logic [N-1:0]         Ack,
  input  logic                 ClrReq,
  output logic                 ClrAck,
  output logic                 CntEn,
  output logic                 CntSlt,
  output logic                 CntRst,
  output logic                 Busy,
  output logic [$clog2(N)-1:0] GrantId
);

  localparam int             GW        = $clog2(N);
  localparam int             BW        = (BEATS1 > 1) ? $clog2(BEATS1) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS1 - 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   ptr, ptr_nxt;
  logic [GW-1:0]   gid_nxt;
  logic [BW-1:0]   beat, beat_nxt;
  logic            arb_vld;
  logic [GW-1:0]   arb_id;

  logic [N-1:0]    ack_nxt;
  logic            clr_ack_nxt, cnt_en_nxt, cnt_slt_nxt, cnt_rst_nxt, busy_nxt;

  rr_arbiter #(.N(N)) u_arb (
    .Req     (Req),
    .ptr     (ptr),
    .Valid   (arb_vld),
    .GrantId (arb_id)
  );

  // State and output registers. Outputs are decoded from the next state so
  // they line up with the state they describe without a combinational path.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ptr     <= '0;
      beat    <= '0;
      GrantId <= '0;
      Ack     <= '0;
      ClrAck  <= 1'b0;
      CntEn   <= 1'b0;
      CntSlt  <= 1'b0;
      CntRst  <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      beat    <= beat_nxt;
      GrantId <= gid_nxt;
      Ack     <= ack_nxt;
      ClrAck  <= clr_ack_nxt;
      CntEn   <= cnt_en_nxt;
      CntSlt  <= cnt_slt_nxt;
      CntRst  <= cnt_rst_nxt;
      Busy    <= busy_nxt;
    end
  end

  // Next-state logic. A channel-1 grant runs all BEATS1 beats regardless of
  // Req/Sel so nothing can split the counter's prescale phase.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gid_nxt   = GrantId;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        gid_nxt  = '0;
        beat_nxt = '0;
        if (ClrReq) begin
          state_nxt = CLEAR;
        end else if (arb_vld) begin
          gid_nxt   = arb_id;
          state_nxt = (Sel[arb_id] == CH1) ? ISSUE1 : ISSUE0;
          ptr_nxt   = (arb_id == GW'(N - 1)) ? '0 : arb_id + 1'b1;
        end
      end
      ISSUE0: begin
        state_nxt = IDLE;
        gid_nxt   = '0;
      end
      ISSUE1: begin
        if (beat == LAST_BEAT) begin
          state_nxt = IDLE;
          gid_nxt   = '0;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      CLEAR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode of the next state; Ack lands on the final issue cycle.
  always_comb begin
    ack_nxt = '0;
    if (state_nxt == ISSUE0 || (state_nxt == ISSUE1 && beat_nxt == LAST_BEAT)) begin
      ack_nxt[gid_nxt] = 1'b1;
    end
    cnt_en_nxt  = (state_nxt == ISSUE0) || (state_nxt == ISSUE1);
    cnt_slt_nxt = (state_nxt == ISSUE1) ? CH1 : CH0;
    cnt_rst_nxt = (state_nxt == CLEAR);
    clr_ack_nxt = (state_nxt == CLEAR);
    busy_nxt    = (state_nxt != IDLE);
  end

endmodule
